// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t  : FSM encoding (IDLE/RUN/DONE)
//   DZ_QUOT  : divide-by-zero quotient (all ones), sliced to WIDTH by users;
//              wide enough for any WIDTH up to 64.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [63:0] DZ_QUOT = '1;

endpackage

// File: rtl/fa.sv
// One-bit full adder cell.
//   a, b, ci : addend bits and carry in
//   s, co    : sum and carry out
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: WIDTH+1-bit ripple subtract a - {0,b}.
//   a    : shifted partial remainder (WIDTH+1 bits)
//   b    : divisor (WIDTH bits)
//   diff : low WIDTH bits of the trial difference
//   fits : 1 when the trial MSB is 0, i.e. the divisor fits and the
//          difference becomes the new remainder
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             fits
);
  logic [WIDTH:0] bn;
  logic [WIDTH:0] c;
  logic [WIDTH:0] trial;

  // a - b == a + ~b + 1
  assign bn   = ~{1'b0, b};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fa u_fa (.a(a[i]), .b(bn[i]), .ci(c[i]), .s(trial[i]), .co(c[i+1]));
  end

  // Top bit only needs the sum; its carry out carries no information here.
  assign trial[WIDTH] = a[WIDTH] ^ bn[WIDTH] ^ c[WIDTH];

  assign diff = trial[WIDTH-1:0];
  assign fits = ~trial[WIDTH];
endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   A, B     : dividend / divisor, captured on accepted start
//   busy     : high while iterating
//   done     : one-cycle pulse, Q/R/dz valid
//   Q, R, dz : quotient, remainder, divide-by-zero flag; held until the
//              next completion
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] dq;   // dividend shifts out the top, quotient shifts in
  logic [WIDTH-1:0] dvs;
  // After a restoring step the remainder is always < divisor, so its
  // WIDTH+1-th bit is zero and is not stored; the full WIDTH+1-bit
  // partial remainder is the shifted value below.
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dq_nxt;

  assign shifted = {rem, dq[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .a    (shifted),
    .b    (dvs),
    .diff (diff),
    .fits (fits)
  );

  assign rem_nxt = fits ? diff : shifted[WIDTH-1:0];
  assign dq_nxt  = {dq[WIDTH-2:0], fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
      count <= '0;
      dq    <= '0;
      dvs   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (B == '0) begin
              state <= DONE;
              done  <= 1'b1;
              Q     <= DZ_QUOT[WIDTH-1:0];
              R     <= A;
              dz    <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              dq    <= A;
              dvs   <= B;
              rem   <= '0;
              count <= CW'(WIDTH);
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dq    <= dq_nxt;
          rem   <= rem_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Q     <= dq_nxt;
            R     <= rem_nxt;
            dz    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
